// File: rtl/rtc_bus_sequencer.sv
// Multiplexed address/data RTC bus engine: timed strobes, bursts, write stream.
// Optional nibble range check on read data when RTC_BCD_CHECK_EN is defined.
module rtc_bus_sequencer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 4,
    parameter int T_SU   = 2,
    parameter int T_PW   = 4,
    parameter int T_HD   = 2,
    parameter int T_GAP  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
`ifdef RTC_BCD_CHECK_EN
    output logic              rd_bcd_err,
    output logic              bcd_err_seen,
`endif
    inout  wire  [DATA_W-1:0] dato,
    output logic              a_d,
    output logic              cs,
    output logic              rd,
    output logic              wr
);

    localparam int T_M1  = (T_SU > T_PW) ? T_SU : T_PW;
    localparam int T_M2  = (T_HD > T_GAP) ? T_HD : T_GAP;
    localparam int T_MAX = (T_M1 > T_M2) ? T_M1 : T_M2;
    localparam int CNT_W = $clog2(T_MAX + 1);

    localparam logic [CNT_W-1:0] C_SU  = CNT_W'(T_SU - 1);
    localparam logic [CNT_W-1:0] C_PW  = CNT_W'(T_PW - 1);
    localparam logic [CNT_W-1:0] C_HD  = CNT_W'(T_HD - 1);
    localparam logic [CNT_W-1:0] C_GAP = CNT_W'(T_GAP - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WD_WAIT,
        S_ADDR_SU,
        S_ADDR_PW,
        S_ADDR_HD,
        S_DATA_SU,
        S_DATA_PW,
        S_DATA_HD,
        S_GAP
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]  r_addr;
    logic [LEN_W-1:0]   r_rem;
    logic               r_write;
    logic [DATA_W-1:0]  r_wdat;
    logic               r_wdata_ready;
    logic               r_cmd_ready;
    logic               r_busy;
    logic               r_done;
    logic               r_rd_valid;
    logic [DATA_W-1:0]  r_rd_data;
    logic [ADDR_W-1:0]  r_rd_addr;
    logic               r_cs;
    logic               r_rd;
    logic               r_wr;
    logic               r_ad;
    logic               r_drive;
    logic [DATA_W-1:0]  r_dout;

    state_t             w_nstate;
    logic [CNT_W-1:0]   w_ncnt;
    logic [ADDR_W-1:0]  w_naddr;
    logic               w_nwrite;
    logic               w_last;
    logic               w_aphase;
    logic               w_dphase;

    always_comb begin
        w_nstate = r_state;
        w_ncnt   = (r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
        w_naddr  = r_addr;
        w_nwrite = r_write;
        w_last   = (r_cnt == '0);
        unique case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_nwrite = cmd_write;
                    w_naddr  = cmd_addr;
                    w_nstate = cmd_write ? S_WD_WAIT : S_ADDR_SU;
                    w_ncnt   = C_SU;
                end
            end
            S_WD_WAIT: begin
                if (r_wdata_ready) begin
                    w_nstate = S_ADDR_SU;
                    w_ncnt   = C_SU;
                end
            end
            S_ADDR_SU: begin
                if (w_last) begin
                    w_nstate = S_ADDR_PW;
                    w_ncnt   = C_PW;
                end
            end
            S_ADDR_PW: begin
                if (w_last) begin
                    w_nstate = S_ADDR_HD;
                    w_ncnt   = C_HD;
                end
            end
            S_ADDR_HD: begin
                if (w_last) begin
                    w_nstate = S_DATA_SU;
                    w_ncnt   = C_SU;
                end
            end
            S_DATA_SU: begin
                if (w_last) begin
                    w_nstate = S_DATA_PW;
                    w_ncnt   = C_PW;
                end
            end
            S_DATA_PW: begin
                if (w_last) begin
                    w_nstate = S_DATA_HD;
                    w_ncnt   = C_HD;
                end
            end
            S_DATA_HD: begin
                if (w_last) begin
                    w_nstate = S_GAP;
                    w_ncnt   = C_GAP;
                end
            end
            S_GAP: begin
                if (w_last) begin
                    if (r_rem == '0) begin
                        w_nstate = S_IDLE;
                    end else begin
                        w_naddr  = r_addr + 1'b1;
                        w_nstate = r_write ? S_WD_WAIT : S_ADDR_SU;
                        w_ncnt   = C_SU;
                    end
                end
            end
            default: ;
        endcase
    end

    assign w_aphase = (w_nstate == S_ADDR_SU) || (w_nstate == S_ADDR_PW) ||
                      (w_nstate == S_ADDR_HD);
    assign w_dphase = (w_nstate == S_DATA_SU) || (w_nstate == S_DATA_PW) ||
                      (w_nstate == S_DATA_HD);

`ifdef RTC_BCD_CHECK_EN
    logic r_bcd_err;
    logic r_bcd_seen;

    function automatic logic bcd_bad(input logic [DATA_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i + 4 <= DATA_W; i += 4) begin
            if (v[i+:4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bcd_err  <= 1'b0;
            r_bcd_seen <= 1'b0;
        end else begin
            if (r_state == S_IDLE && cmd_valid) begin
                r_bcd_seen <= 1'b0;
            end
            if (r_state == S_DATA_PW && w_last && !r_write) begin
                r_bcd_err <= bcd_bad(dato);
                if (bcd_bad(dato)) r_bcd_seen <= 1'b1;
            end
        end
    end

    assign rd_bcd_err   = r_bcd_err;
    assign bcd_err_seen = r_bcd_seen;
`endif

    // Strobes and bus drive are decoded from the next state so every pin is a flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_addr        <= '0;
            r_rem         <= '0;
            r_write       <= 1'b0;
            r_wdat        <= '0;
            r_wdata_ready <= 1'b0;
            r_cmd_ready   <= 1'b1;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_rd_valid    <= 1'b0;
            r_rd_data     <= '0;
            r_rd_addr     <= '0;
            r_cs          <= 1'b1;
            r_rd          <= 1'b1;
            r_wr          <= 1'b1;
            r_ad          <= 1'b1;
            r_drive       <= 1'b0;
            r_dout        <= '0;
        end else begin
            r_state       <= w_nstate;
            r_cnt         <= w_ncnt;
            r_addr        <= w_naddr;
            r_write       <= w_nwrite;
            r_cmd_ready   <= (w_nstate == S_IDLE);
            r_done        <= 1'b0;
            r_rd_valid    <= 1'b0;
            r_wdata_ready <= (r_state == S_WD_WAIT) && wdata_valid &&
                             !r_wdata_ready;
            if (r_state == S_WD_WAIT && r_wdata_ready) begin
                r_wdat <= wdata;
            end
            if (r_state == S_IDLE && cmd_valid) begin
                r_rem  <= cmd_len;
                r_busy <= 1'b1;
            end
            if (r_state == S_GAP && w_last) begin
                if (r_rem == '0) begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end else begin
                    r_rem <= r_rem - 1'b1;
                end
            end
            if (r_state == S_DATA_PW && w_last && !r_write) begin
                r_rd_valid <= 1'b1;
                r_rd_data  <= dato;
                r_rd_addr  <= r_addr;
            end
            r_cs    <= !(w_aphase || w_dphase);
            r_ad    <= !w_aphase;
            r_wr    <= !((w_nstate == S_ADDR_PW) ||
                         (w_nstate == S_DATA_PW && w_nwrite));
            r_rd    <= !(w_nstate == S_DATA_PW && !w_nwrite);
            r_drive <= w_aphase || (w_dphase && w_nwrite);
            r_dout  <= w_aphase ? DATA_W'(w_naddr) : r_wdat;
        end
    end

    assign dato        = r_drive ? r_dout : {DATA_W{1'bz}};
    assign cmd_ready   = r_cmd_ready;
    assign wdata_ready = r_wdata_ready;
    assign rd_data     = r_rd_data;
    assign rd_addr     = r_rd_addr;
    assign rd_valid    = r_rd_valid;
    assign busy        = r_busy;
    assign done        = r_done;
    assign cs          = r_cs;
    assign rd          = r_rd;
    assign wr          = r_wr;
    assign a_d         = r_ad;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer with a simple RTC chip register model.
// Covers the RTC_BCD_CHECK_EN ports when that macro is defined.
module tb_rtc_bus_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [3:0] cmd_len;
    logic [7:0] wdata;
    logic       wdata_valid;
    logic       wdata_ready;
    logic [7:0] rd_data;
    logic [7:0] rd_addr;
    logic       rd_valid;
    logic       busy;
    logic       done;
    wire  [7:0] dato;
    logic       a_d;
    logic       cs;
    logic       rd;
    logic       wr;
`ifdef RTC_BCD_CHECK_EN
    logic       rd_bcd_err;
    logic       bcd_err_seen;
`endif

    always #5 clk = ~clk;

    rtc_bus_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .wdata       (wdata),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .rd_data     (rd_data),
        .rd_addr     (rd_addr),
        .rd_valid    (rd_valid),
        .busy        (busy),
        .done        (done),
`ifdef RTC_BCD_CHECK_EN
        .rd_bcd_err  (rd_bcd_err),
        .bcd_err_seen(bcd_err_seen),
`endif
        .dato        (dato),
        .a_d         (a_d),
        .cs          (cs),
        .rd          (rd),
        .wr          (wr)
    );

    // RTC chip: address latched on wr rise in address phase, data on wr rise in data phase
    logic [7:0] mem [256];
    logic [7:0] chip_addr;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        mem[8'h30] <= 8'h59;
        mem[8'hFE] <= 8'h11;
        mem[8'hFF] <= 8'h22;
        mem[8'h00] <= 8'h33;
        mem[8'h01] <= 8'h44;
        mem[8'h50] <= 8'h3A;
        mem[8'h51] <= 8'h39;
        chip_addr  <= 8'h00;
    end

    always @(posedge wr) begin
        if (!cs) begin
            if (!a_d) chip_addr <= dato;
            else mem[chip_addr] <= dato;
        end
    end

    assign dato = (!rd && !cs) ? mem[chip_addr] : 8'hzz;

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    int         cyc = 0;
    int         cs_run = 0;
    int         first_fall = -1;
    int         done_cyc = 0;
    int         done_n = 0;
    int         wrdy_n = 0;
    int         wrdy_cyc = 0;
    int         rd_low = 0;
    int         bus_bad = 0;
    int         cs_runs[$];
    int         rise_q[$];
    int         fall_q[$];
    logic [8:0] wrlow[$];
    logic [15:0] rdq[$];
    logic       bcdq[$];

    logic [7:0] wq[$];
    int         wcons = 0;
    int         hold = 0;
    int         hold_cfg = 0;
    bit         pop_pend = 0;

    task automatic clear_stats();
        cs_run = 0;
        first_fall = -1;
        done_cyc = 0;
        done_n = 0;
        wrdy_n = 0;
        wrdy_cyc = 0;
        rd_low = 0;
        bus_bad = 0;
        wcons = 0;
        cs_runs.delete();
        rise_q.delete();
        fall_q.delete();
        wrlow.delete();
        rdq.delete();
        bcdq.delete();
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!cs) begin
                if (cs_run == 0) begin
                    fall_q.push_back(cyc);
                    if (first_fall < 0) first_fall = cyc;
                end
                cs_run++;
            end else if (cs_run > 0) begin
                cs_runs.push_back(cs_run);
                rise_q.push_back(cyc);
                cs_run = 0;
            end
            if (!wr) wrlow.push_back({a_d, dato});
            if (!rd) begin
                rd_low++;
                if (dato != mem[chip_addr]) bus_bad++;
            end
            if (wdata_ready) begin
                wrdy_n++;
                wrdy_cyc = cyc;
            end
            if (rd_valid) begin
                rdq.push_back({rd_addr, rd_data});
`ifdef RTC_BCD_CHECK_EN
                bcdq.push_back(rd_bcd_err);
`endif
            end
            if (done) begin
                done_n++;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        wdata_valid = 1'b0;
        wdata = 8'h00;
        forever begin
            @(negedge clk);
            if (pop_pend && wq.size() > 0) begin
                void'(wq.pop_front());
                wcons++;
                if (wcons == 1) hold = hold_cfg;
            end
            if (hold > 0 && cs && busy) hold--;
            pop_pend = wdata_ready;
            wdata_valid = (wq.size() > 0) && (hold == 0);
            wdata = (wq.size() > 0) ? wq[0] : 8'h00;
        end
    end

    task automatic run_cmd(input bit w, input logic [7:0] a,
                           input logic [3:0] l, input int budget);
        clear_stats();
        @(negedge clk);
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr = a;
        cmd_len = l;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("busy_on_accept", busy, 1);
        for (int i = 0; i < budget && done_n == 0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("done_seen", done_n, 1);
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        bit         w;
        logic [7:0] addr;
        logic [3:0] len;
        logic [7:0] w0;
        logic [7:0] w1;
        int         nrd;
        logic [7:0] fa;
        logic [7:0] fd;
        logic [7:0] la;
        logic [7:0] ld;
        int         lat;
        int         nwr;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr = 8'h00;
        cmd_len = 4'h0;

        tbl[0] = '{0, 8'h30, 4'd0, 8'h00, 8'h00, 1, 8'h30, 8'h59, 8'h30, 8'h59, 19, 0};
        tbl[1] = '{0, 8'hFE, 4'd3, 8'h00, 8'h00, 4, 8'hFE, 8'h11, 8'h01, 8'h44, 76, 0};
        tbl[2] = '{1, 8'h40, 4'd1, 8'hA1, 8'hB2, 0, 8'h00, 8'h00, 8'h00, 8'h00, 40, 2};
        tbl[3] = '{0, 8'h40, 4'd1, 8'h00, 8'h00, 2, 8'h40, 8'hA1, 8'h41, 8'hB2, 38, 0};
        tbl[4] = '{1, 8'hFF, 4'd1, 8'hC3, 8'hD4, 0, 8'h00, 8'h00, 8'h00, 8'h00, 40, 2};
        tbl[5] = '{0, 8'h00, 4'd0, 8'h00, 8'h00, 1, 8'h00, 8'hD4, 8'h00, 8'hD4, 19, 0};

        repeat (3) @(negedge clk);
        chk("rst_strobes", {cs, rd, wr, a_d}, 4'hF);
        chk("rst_flags", {busy, done, rd_valid, wdata_ready}, 4'h0);
        chk("rst_rd_data", rd_data, 8'h00);
        chk("rst_rd_addr", rd_addr, 8'h00);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // single write with strobe/bus timing
        wq.push_back(8'h45);
        run_cmd(1'b1, 8'h21, 4'd0, 200);
        chk("wr1_cs_runs", cs_runs.size(), 1);
        chk("wr1_cs_low", cs_runs[0], 16);
        chk("wr1_wr_low", wrlow.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk("wr1_bus", wrlow[i], (i < 4) ? 9'h021 : 9'h145);
        end
        chk("wr1_done_after_rise", done_cyc - rise_q[0], 3);
        chk("wr1_mem", mem[8'h21], 8'h45);
        chk("wr1_wrdy", wrdy_n, 1);
        chk("wr1_wrdy_to_fall", fall_q[0] - wrdy_cyc, 1);

        for (int v = 0; v < 6; v++) begin
            wq.delete();
            if (tbl[v].w) begin
                wq.push_back(tbl[v].w0);
                if (tbl[v].len > 0) wq.push_back(tbl[v].w1);
            end
            run_cmd(tbl[v].w, tbl[v].addr, tbl[v].len, 400);
            chk("vec_latency", done_cyc - first_fall, tbl[v].lat);
            chk("vec_nrd", rdq.size(), tbl[v].nrd);
            chk("vec_rd_low", rd_low, 4 * tbl[v].nrd);
            chk("vec_bus", bus_bad, 0);
            chk("vec_wrdy", wrdy_n, tbl[v].nwr);
            foreach (cs_runs[k]) chk("vec_cs_low", cs_runs[k], 16);
            if (tbl[v].nrd > 0) begin
                chk("vec_first_rd", rdq[0], {tbl[v].fa, tbl[v].fd});
                chk("vec_last_rd", rdq[rdq.size() - 1], {tbl[v].la, tbl[v].ld});
            end
        end

        // write stream stall between accesses
        wq.delete();
        wq.push_back(8'h66);
        wq.push_back(8'h77);
        hold_cfg = 50;
        run_cmd(1'b1, 8'h60, 4'd1, 400);
        hold_cfg = 0;
        chk("stall_cs_runs", cs_runs.size(), 2);
        chk("stall_gap_ge50", (fall_q[1] - rise_q[0]) >= 50, 1);
        chk("stall_wrdy_to_fall", fall_q[1] - wrdy_cyc, 1);
        chk("stall_mem0", mem[8'h60], 8'h66);
        chk("stall_mem1", mem[8'h61], 8'h77);

        // reset during a read strobe
        clear_stats();
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr = 8'hFE;
        cmd_len = 4'd3;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 60 && rd; i++) @(negedge clk);
        chk("rst_mid_reach_pw", rd, 0);
        reset = 1'b0;
        #1;
        chk("rst_mid_strobes", {cs, rd, wr, a_d}, 4'hF);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        repeat (3) @(negedge clk);
        chk("rst_mid_no_done", done_n, 0);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_mid_ready", cmd_ready, 1);
        run_cmd(1'b0, 8'h30, 4'd0, 200);
        chk("rst_mid_rerun", rdq[0], {8'h30, 8'h59});

`ifdef RTC_BCD_CHECK_EN
        run_cmd(1'b0, 8'h50, 4'd0, 200);
        chk("bcd_bad_err", bcdq[0], 1);
        chk("bcd_bad_seen", bcd_err_seen, 1);
        run_cmd(1'b0, 8'h51, 4'd0, 200);
        chk("bcd_ok_err", bcdq[0], 0);
        chk("bcd_ok_seen", bcd_err_seen, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
